ppu_video_out: RTL and testbench
================================

PPU_VIDEO_OUT -- requirements
Module: ppu_video_out

Interface
REQ-001 SHALL have parameter H_TOTAL, default 341, dots per scanline.
REQ-002 SHALL have parameter V_TOTAL, default 262, scanlines per frame.
REQ-003 SHALL have parameter VIS_W, default 256, visible dots per line (dots 1..VIS_W).
REQ-004 SHALL have parameter VIS_H, default 240, visible scanlines (0..VIS_H-1).
REQ-005 SHALL have parameter VBL_LINE, default 241, scanline on which vblank/frame starts.
REQ-006 clk  input  1  single clock, one dot per rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 pal_idx  input  6  palette index of the current dot from the render pipeline.
REQ-009 greyscale  input  1  mask bit; when 1, colour field forced to 0.
REQ-010 render_en  input  1  background or sprite rendering enabled.
REQ-011 dot  output  9  current dot counter, 0..H_TOTAL-1.
REQ-012 scanline  output  9  current scanline counter, 0..V_TOTAL-1.
REQ-013 pixel  output  8  registered pixel; [7:6]=0, [5:0]=palette index.
REQ-014 pixel_en  output  1  registered strobe, pixel valid this cycle.
REQ-015 frame  output  1  registered; high from vblank start to pre-render line.
REQ-016 odd  output  1  frame parity, toggles at each frame wrap.

Function
REQ-017 SHALL advance dot by 1 every clk; at dot H_TOTAL-1, dot SHALL wrap to 0 and scanline SHALL increment.
REQ-018 At scanline V_TOTAL-1, dot H_TOTAL-1, scanline SHALL wrap to 0 and odd SHALL toggle.
REQ-019 pixel_en SHALL be 1 exactly one cycle after a cycle with scanline < VIS_H and 1 <= dot <= VIS_W; else 0.
REQ-020 pixel SHALL equal, one cycle after sampling, {2'b00, greyscale ? (pal_idx & 6'h30) : pal_idx}.
REQ-021 pixel SHALL hold its last value when pixel_en is 0.
REQ-022 frame SHALL go 1 one cycle after a cycle with (scanline=VBL_LINE, dot=1) and go 0 one cycle after (scanline=V_TOTAL-1, dot=1).
REQ-023 Exactly VIS_W*VIS_H (61440 default) pixel_en pulses SHALL occur between consecutive frame rising edges.
REQ-024 dot and scanline outputs SHALL be the counter registers directly (zero latency).
REQ-025 Counter arithmetic SHALL be 9-bit unsigned; no state outside 0..H_TOTAL-1 / 0..V_TOTAL-1 SHALL be reachable.
REQ-026 render_en and greyscale changes mid-line SHALL take effect on the next sampled dot; no glitch on frame/pixel_en.

Reset
REQ-027 On rst low, asynchronously: dot=0, scanline=0, pixel=8'h00, pixel_en=0, frame=0, odd=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; counting SHALL restart at (0,0) on the first clk after rst rises, with even parity.
REQ-029 First pixel_en after reset release SHALL occur 2 cycles after release (dot 1 sampled, then registered).

Configuration
REQ-030 Macro ODD_FRAME_SKIP_EN: when defined, if odd=1 and render_en=1 sampled at (scanline V_TOTAL-1, dot H_TOTAL-2), next state SHALL be (0,0) and odd SHALL toggle, skipping dot H_TOTAL-1.
REQ-031 When ODD_FRAME_SKIP_EN is undefined, every frame SHALL be exactly H_TOTAL*V_TOTAL cycles regardless of render_en or odd.

Verification
REQ-032 Reset release, run 1 frame -> frame rises at cycle 82183 after release (241*341+1, +1 register), 61440 pixel_en pulses before it.
REQ-033 Default params, skip compiled out -> successive frame rising edges exactly 89342 cycles apart; odd toggles each frame.
REQ-034 ODD_FRAME_SKIP_EN defined, render_en=1 -> frame periods alternate 89342 / 89341 cycles; render_en=0 -> all 89342.
REQ-035 pal_idx=6'h2A, greyscale=1 on a visible dot -> pixel=8'h20 next cycle; greyscale=0 -> 8'h2A.
REQ-036 Assert rst low at scanline 100 dot 200 -> all outputs zero immediately (no clk); after release, dot=1 at first edge, pixel_en=1 at second edge.
REQ-037 Check boundaries: dot 340->0 with scanline increment; scanline 261->0; pixel_en low at dot 0 and dot 257, high at dots 1 and 256 (registered).

Source files
------------

// File: rtl/ppu_video_out.sv
// PPU video timing: dot/scanline counters, registered pixel output and vblank frame flag.
// Build option ODD_FRAME_SKIP_EN: drop the last dot of odd frames while rendering is enabled.
module ppu_video_out #(
  parameter int H_TOTAL  = 341,
  parameter int V_TOTAL  = 262,
  parameter int VIS_W    = 256,
  parameter int VIS_H    = 240,
  parameter int VBL_LINE = 241
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pal_idx,
  input  logic       greyscale,
  input  logic       render_en,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic [7:0] pixel,
  output logic       pixel_en,
  output logic       frame,
  output logic       odd
);

  localparam logic [8:0] DOT_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] DOT_SKIP  = 9'(H_TOTAL - 2);
  localparam logic [8:0] LINE_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] LINE_VBL  = 9'(VBL_LINE);
  localparam logic [8:0] VIS_W_LIM = 9'(VIS_W);
  localparam logic [8:0] VIS_H_LIM = 9'(VIS_H);

  logic       last_dot;
  logic       last_line;
  logic       skip;
  logic       line_end;
  logic       visible;
  logic       frame_nxt;
  logic       odd_nxt;
  logic [8:0] dot_nxt;
  logic [8:0] line_nxt;
  logic [5:0] colour;

`ifndef ODD_FRAME_SKIP_EN
  logic unused_render_en;
  assign unused_render_en = render_en;
`endif

  always_comb begin
    last_dot  = (dot == DOT_LAST);
    last_line = (scanline == LINE_LAST);
`ifdef ODD_FRAME_SKIP_EN
    skip      = odd & render_en & last_line & (dot == DOT_SKIP);
`else
    skip      = 1'b0;
`endif
    line_end  = last_dot | skip;
    visible   = (scanline < VIS_H_LIM) && (dot >= 9'd1) && (dot <= VIS_W_LIM);
    colour    = greyscale ? (pal_idx & 6'h30) : pal_idx;
  end

  // Counters only ever wrap on an exact terminal match, so out-of-range states are unreachable.
  always_comb begin
    dot_nxt  = dot + 9'd1;
    line_nxt = scanline;
    odd_nxt  = odd;
    if (line_end) begin
      dot_nxt = 9'd0;
      if (last_line) begin
        line_nxt = 9'd0;
        odd_nxt  = ~odd;
      end else begin
        line_nxt = scanline + 9'd1;
      end
    end
  end

  always_comb begin
    frame_nxt = frame;
    if (scanline == LINE_VBL && dot == 9'd1) begin
      frame_nxt = 1'b1;
    end else if (last_line && dot == 9'd1) begin
      frame_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dot      <= 9'd0;
      scanline <= 9'd0;
      odd      <= 1'b0;
      frame    <= 1'b0;
      pixel_en <= 1'b0;
      pixel    <= 8'h00;
    end else begin
      dot      <= dot_nxt;
      scanline <= line_nxt;
      odd      <= odd_nxt;
      frame    <= frame_nxt;
      pixel_en <= visible;
      if (visible) begin
        pixel <= {2'b00, colour};
      end
    end
  end

endmodule

// File: tb/tb_ppu_video_out.sv
// Scoreboard bench for ppu_video_out on a reduced raster; model tracks linear position within the frame.
module tb_ppu_video_out;

  localparam int H     = 24;
  localparam int V     = 14;
  localparam int VW    = 16;
  localparam int VH    = 10;
  localparam int VBL   = 11;
  localparam int FRAME = H * V;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pal_idx;
  logic       greyscale;
  logic       render_en;
  logic [8:0] dot;
  logic [8:0] scanline;
  logic [7:0] pixel;
  logic       pixel_en;
  logic       frame;
  logic       odd;

  int n_checks = 0;
  int n_fail   = 0;

  ppu_video_out #(
    .H_TOTAL(H), .V_TOTAL(V), .VIS_W(VW), .VIS_H(VH), .VBL_LINE(VBL)
  ) dut (
    .clk(clk), .rst(rst), .pal_idx(pal_idx), .greyscale(greyscale), .render_en(render_en),
    .dot(dot), .scanline(scanline), .pixel(pixel), .pixel_en(pixel_en), .frame(frame), .odd(odd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: position p = scanline*H + dot after the most recent edge.
  int         m_p     = 0;
  int         m_edges = 0;
  bit         m_odd   = 0;
  bit         m_frame = 0;
  bit         m_pen   = 0;
  logic [7:0] exp_q[$];

  initial begin : model
    int  line;
    int  d;
    int  pix;
    bit  wrap;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_p = 0; m_edges = 0; m_odd = 0; m_frame = 0; m_pen = 0;
        exp_q.delete();
      end else begin
        line = m_p / H;
        d    = m_p % H;
        m_edges++;
        m_pen = (line < VH) && (d >= 1) && (d <= VW);
        if (m_pen) begin
          pix = greyscale ? (int'(pal_idx) / 16) * 16 : int'(pal_idx);
          exp_q.push_back(8'(pix));
        end
        if (line == VBL && d == 1) m_frame = 1;
        else if (line == V - 1 && d == 1) m_frame = 0;
        wrap = (m_p == FRAME - 1);
`ifdef ODD_FRAME_SKIP_EN
        if (m_odd && render_en && m_p == FRAME - 2) wrap = 1;
`endif
        if (wrap) begin
          m_p   = 0;
          m_odd = !m_odd;
        end else begin
          m_p++;
        end
      end
    end
  end

  initial begin : monitor
    logic [7:0] last_pix;
    logic [7:0] exp_pix;
    int         pulses;
    int         last_rise;
    int         period;
    bit         seen_rise;
    bit         prev_frame;
    last_pix = 8'h00; pulses = 0; last_rise = 0; seen_rise = 0; prev_frame = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_pix = 8'h00; pulses = 0; seen_rise = 0; prev_frame = 0;
      end else begin
        check("dot", int'(dot), m_p % H);
        check("scanline", int'(scanline), m_p / H);
        check("frame", int'(frame), int'(m_frame));
        check("odd", int'(odd), int'(m_odd));
        check("pixel_en", int'(pixel_en), int'(m_pen));
        if (pixel_en) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pixel_queue: got pixel_en=1, want no pixel pending at %0t", $time);
          end else begin
            exp_pix = exp_q.pop_front();
            n_checks--;
            check("pixel", int'(pixel), int'(exp_pix));
            last_pix = exp_pix;
          end
          pulses++;
        end else begin
          check("pixel_hold", int'(pixel), int'(last_pix));
        end
        if (frame && !prev_frame) begin
          if (!seen_rise) begin
            check("first_rise_cycle", m_edges, VBL * H + 2);
          end else begin
            period = m_edges - last_rise;
`ifdef ODD_FRAME_SKIP_EN
            check("frame_period", int'(period == FRAME || period == FRAME - 1), 1);
`else
            check("frame_period", period, FRAME);
`endif
          end
          check("pulses_per_frame", pulses, VW * VH);
          pulses    = 0;
          last_rise = m_edges;
          seen_rise = 1;
        end
        prev_frame = frame;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_dot"}, int'(dot), 0);
    check({tag, "_scanline"}, int'(scanline), 0);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_pixel_en"}, int'(pixel_en), 0);
    check({tag, "_frame"}, int'(frame), 0);
    check({tag, "_odd"}, int'(odd), 0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pal_idx   = ($urandom_range(0, 7) == 0) ? 6'h2A : 6'($urandom);
      greyscale = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin : stimulus
    bit found;
    rst = 1'b0; pal_idx = 6'h00; greyscale = 1'b0; render_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    for (int f = 0; f < 7; f++) begin
      render_en = (f < 4) || (f == 6);
      run_cycles(FRAME);
    end

    // Abort mid-frame inside vblank so frame and odd are both nonzero beforehand.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      #1;
      if (scanline == 9'd12 && dot == 9'd13) found = 1;
    end
    check("reset_target_reached", int'(found), 1);
    rst = 1'b0;
    #1;
    check_zero("midframe_reset");
    pal_idx = 6'h2A; greyscale = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("restart_dot", int'(dot), 1);
    check("restart_pixel_en", int'(pixel_en), 0);
    @(posedge clk);
    #1;
    check("first_pixel_en", int'(pixel_en), 1);
    check("grey_pixel", int'(pixel), 8'h20);
    greyscale = 1'b0;
    @(posedge clk);
    #1;
    check("colour_pixel", int'(pixel), 8'h2A);

    render_en = 1'b1;
    run_cycles(2 * FRAME + 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
